// File: rtl/rdsel_pkg.sv
// Shared load/store size encodings and helpers for the read-data select path.
package rdsel_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE  = 2'd0,
      SZ_HALF  = 2'd1,
      SZ_WORD  = 2'd2,
      SZ_DWORD = 2'd3
   } rdsel_size_e;

   function automatic int size_bytes(input logic [1:0] size);
      return 1 << size;
   endfunction

endpackage

// File: rtl/rdsel_extract.sv
// Combinational lane select + zero/sign extend + misalign/oversize flags.
module rdsel_extract
   import rdsel_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   localparam int OFF_WIDTH = $clog2(DATA_WIDTH/8)
) (
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic [OFF_WIDTH-1:0]  off_i,
   input  logic [1:0]            size_i,
   input  logic                  signed_i,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic                  misalign_o,
   output logic                  oversize_o
);

   localparam int NBYTES = DATA_WIDTH / 8;

   logic [DATA_WIDTH-1:0] shifted;
   logic [DATA_WIDTH-1:0] extended;
   logic                  sign_bit;
   int                    nbytes_req;
   int                    lane_bits;

   always_comb begin
      shifted    = data_i >> {off_i, 3'b000};
      nbytes_req = size_bytes(size_i);
      lane_bits  = nbytes_req * 8;
      oversize_o = (nbytes_req > NBYTES);
      misalign_o = !oversize_o && ((int'(off_i) & (nbytes_req - 1)) != 0);

      // Lane MSB located by scan so the size may exceed the word without an out-of-range slice.
      sign_bit = 1'b0;
      for (int i = 0; i < DATA_WIDTH; i++) begin
         if (i == lane_bits - 1) sign_bit = shifted[i];
      end

      extended = '0;
      for (int i = 0; i < DATA_WIDTH; i++) begin
         if (i < lane_bits) extended[i] = shifted[i];
         else               extended[i] = signed_i & sign_bit;
      end

      data_o = (oversize_o || misalign_o) ? '0 : extended;
   end

endmodule

// File: rtl/rdsel_align_pipe.sv
// Load-data aligner: extract stage feeding an output register plus one skid entry,
// with a saturating counter of flagged results delivered downstream.
module rdsel_align_pipe #(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 16,
   localparam int OFF_WIDTH = $clog2(DATA_WIDTH/8)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic [OFF_WIDTH-1:0]  in_off,
   input  logic [1:0]            in_size,
   input  logic                  in_signed,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_misalign,
   output logic                  out_oversize,
   output logic [CNT_WIDTH-1:0]  err_cnt,
   input  logic                  err_cnt_clr
);

   typedef struct packed {
      logic [DATA_WIDTH-1:0] data;
      logic                  mis;
      logic                  ovs;
   } entry_t;

   entry_t                new_entry;
   entry_t                out_q, out_d;
   entry_t                skid_q, skid_d;
   logic                  out_valid_q, out_valid_d;
   logic                  skid_valid_q, skid_valid_d;
   logic                  in_ready_q, in_ready_d;
   logic [CNT_WIDTH-1:0]  err_cnt_q, err_cnt_d;
   logic                  accept;
   logic                  consume;

   rdsel_extract #(.DATA_WIDTH(DATA_WIDTH)) u_extract (
      .data_i     (in_data),
      .off_i      (in_off),
      .size_i     (in_size),
      .signed_i   (in_signed),
      .data_o     (new_entry.data),
      .misalign_o (new_entry.mis),
      .oversize_o (new_entry.ovs)
   );

   assign accept  = in_valid & in_ready_q;
   assign consume = out_valid_q & out_ready;

   // Handshake: a transfer happens on a rising edge where valid & ready are both high;
   // out_* stays stable while out_valid & !out_ready, in_ready is a registered "skid empty".
   always_comb begin
      out_d        = out_q;
      skid_d       = skid_q;
      out_valid_d  = out_valid_q;
      skid_valid_d = skid_valid_q;
      err_cnt_d    = err_cnt_q;

      if (consume) begin
         if (skid_valid_q) begin
            out_d        = skid_q;
            skid_valid_d = 1'b0;
         end else begin
            out_valid_d  = 1'b0;
         end
      end

      if (accept) begin
         if (!out_valid_d) begin
            out_d        = new_entry;
            out_valid_d  = 1'b1;
         end else begin
            skid_d       = new_entry;
            skid_valid_d = 1'b1;
         end
      end

      in_ready_d = !skid_valid_d;

      if (err_cnt_clr) begin
         err_cnt_d = '0;
      end else if (consume && (out_q.mis || out_q.ovs) && (err_cnt_q != '1)) begin
         err_cnt_d = err_cnt_q + CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_q        <= '0;
         skid_q       <= '0;
         out_valid_q  <= 1'b0;
         skid_valid_q <= 1'b0;
         in_ready_q   <= 1'b1;
         err_cnt_q    <= '0;
      end else begin
         out_q        <= out_d;
         skid_q       <= skid_d;
         out_valid_q  <= out_valid_d;
         skid_valid_q <= skid_valid_d;
         in_ready_q   <= in_ready_d;
         err_cnt_q    <= err_cnt_d;
      end
   end

   // With the skid full in_ready is low, so accept and a skid-to-output move never coincide.
   assert property (@(posedge clk) disable iff (rst) !(accept && consume && skid_valid_q))
      else $error("accept while skid full and draining");

   assign in_ready     = in_ready_q;
   assign out_valid    = out_valid_q;
   assign out_data     = out_q.data;
   assign out_misalign = out_q.mis;
   assign out_oversize = out_q.ovs;
   assign err_cnt      = err_cnt_q;

endmodule

// File: tb/tb_rdsel_align_pipe.sv
// Directed bench for rdsel_align_pipe: a 32-bit instance and a 64-bit instance with a 2-bit counter.
module tb_rdsel_align_pipe;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // 32-bit instance
   logic        v32 = 0, r32, ov32, ordy32 = 1, sg32 = 0, mis32, ovs32, clr32 = 0;
   logic [31:0] d32 = 0, od32;
   logic [1:0]  off32 = 0, sz32 = 0;
   logic [15:0] cnt32;

   // 64-bit instance
   logic        v64 = 0, r64, ov64, ordy64 = 1, sg64 = 0, mis64, ovs64, clr64 = 0;
   logic [63:0] d64 = 0, od64;
   logic [2:0]  off64 = 0;
   logic [1:0]  sz64 = 0;
   logic [1:0]  cnt64;

   rdsel_align_pipe #(.DATA_WIDTH(32), .CNT_WIDTH(16)) u32 (
      .clk(clk), .rst(rst), .in_valid(v32), .in_ready(r32), .in_data(d32), .in_off(off32),
      .in_size(sz32), .in_signed(sg32), .out_valid(ov32), .out_ready(ordy32), .out_data(od32),
      .out_misalign(mis32), .out_oversize(ovs32), .err_cnt(cnt32), .err_cnt_clr(clr32)
   );

   rdsel_align_pipe #(.DATA_WIDTH(64), .CNT_WIDTH(2)) u64 (
      .clk(clk), .rst(rst), .in_valid(v64), .in_ready(r64), .in_data(d64), .in_off(off64),
      .in_size(sz64), .in_signed(sg64), .out_valid(ov64), .out_ready(ordy64), .out_data(od64),
      .out_misalign(mis64), .out_oversize(ovs64), .err_cnt(cnt64), .err_cnt_clr(clr64)
   );

   typedef struct {
      logic        dw64;
      logic [63:0] data;
      logic [2:0]  off;
      logic [1:0]  size;
      logic        sgn;
      logic [63:0] exp;
      logic        mis;
      logic        ovs;
   } vec_t;

   int total = 0;
   int bad   = 0;
   int exp_cnt32 = 0;
   int exp_cnt64 = 0;
   logic [31:0] exp_q[$];
   vec_t tbl[18];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // One request through an idle pipe: result one cycle after accept, then drained.
   task automatic send(input vec_t v, input logic clr, input string tag);
      @(negedge clk);
      if (v.dw64) begin
         chk({tag, "_in_ready"}, 64'(r64), 64'd1);
         v64 = 1; d64 = v.data; off64 = v.off; sz64 = v.size; sg64 = v.sgn; ordy64 = 1;
      end else begin
         chk({tag, "_in_ready"}, 64'(r32), 64'd1);
         v32 = 1; d32 = v.data[31:0]; off32 = v.off[1:0]; sz32 = v.size; sg32 = v.sgn; ordy32 = 1;
      end
      @(posedge clk); #1;
      v64 = 0; v32 = 0;
      if (v.dw64) begin
         chk({tag, "_valid"}, 64'(ov64), 64'd1);
         chk({tag, "_data"},  od64, v.exp);
         chk({tag, "_mis"},   64'(mis64), 64'(v.mis));
         chk({tag, "_ovs"},   64'(ovs64), 64'(v.ovs));
         clr64 = clr;
         if (clr) exp_cnt64 = 0;
         else if ((v.mis || v.ovs) && exp_cnt64 < 3) exp_cnt64++;
      end else begin
         chk({tag, "_valid"}, 64'(ov32), 64'd1);
         chk({tag, "_data"},  64'(od32), v.exp);
         chk({tag, "_mis"},   64'(mis32), 64'(v.mis));
         chk({tag, "_ovs"},   64'(ovs32), 64'(v.ovs));
         clr32 = clr;
         if (clr) exp_cnt32 = 0;
         else if ((v.mis || v.ovs) && exp_cnt32 < 65535) exp_cnt32++;
      end
      @(posedge clk); #1;
      clr32 = 0; clr64 = 0;
      if (v.dw64) begin
         chk({tag, "_cnt"},   64'(cnt64), 64'(exp_cnt64));
         chk({tag, "_drain"}, 64'(ov64), 64'd0);
      end else begin
         chk({tag, "_cnt"},   64'(cnt32), 64'(exp_cnt32));
         chk({tag, "_drain"}, 64'(ov32), 64'd0);
      end
   endtask

   initial begin
      int k, cons, first, last;
      logic acc_now, cons_now;
      vec_t sat;

      tbl[0]  = '{0, 64'h8001_F0FE, 3'd2, 2'd1, 1, 64'hFFFF_8001, 0, 0};
      tbl[1]  = '{0, 64'h8001_F0FE, 3'd0, 2'd0, 0, 64'h0000_00FE, 0, 0};
      tbl[2]  = '{0, 64'h8001_F0FE, 3'd0, 2'd0, 1, 64'hFFFF_FFFE, 0, 0};
      tbl[3]  = '{0, 64'h8001_F0FE, 3'd1, 2'd2, 0, 64'h0,         1, 0};
      tbl[4]  = '{0, 64'h8001_F0FE, 3'd0, 2'd3, 0, 64'h0,         0, 1};
      tbl[5]  = '{0, 64'h8001_F0FE, 3'd1, 2'd3, 1, 64'h0,         0, 1};
      tbl[6]  = '{0, 64'h8001_F0FE, 3'd3, 2'd0, 1, 64'hFFFF_FF80, 0, 0};
      tbl[7]  = '{0, 64'h8001_F0FE, 3'd1, 2'd0, 0, 64'h0000_00F0, 0, 0};
      tbl[8]  = '{0, 64'h8001_F0FE, 3'd0, 2'd1, 1, 64'hFFFF_F0FE, 0, 0};
      tbl[9]  = '{0, 64'h8001_F0FE, 3'd0, 2'd2, 1, 64'h8001_F0FE, 0, 0};
      tbl[10] = '{0, 64'h8001_F0FE, 3'd3, 2'd1, 0, 64'h0,         1, 0};
      tbl[11] = '{1, 64'h8765_4321_0000_0000, 3'd4, 2'd2, 1, 64'hFFFF_FFFF_8765_4321, 0, 0};
      tbl[12] = '{1, 64'h8765_4321_0000_0000, 3'd0, 2'd3, 1, 64'h8765_4321_0000_0000, 0, 0};
      tbl[13] = '{1, 64'h8765_4321_0000_0000, 3'd4, 2'd2, 0, 64'h0000_0000_8765_4321, 0, 0};
      tbl[14] = '{1, 64'h8765_4321_0000_0000, 3'd6, 2'd1, 0, 64'h0000_0000_0000_8765, 0, 0};
      tbl[15] = '{1, 64'h8765_4321_0000_0000, 3'd7, 2'd0, 1, 64'hFFFF_FFFF_FFFF_FF87, 0, 0};
      tbl[16] = '{1, 64'h8765_4321_0000_0000, 3'd2, 2'd2, 0, 64'h0,                   1, 0};
      tbl[17] = '{1, 64'h8765_4321_0000_0000, 3'd4, 2'd3, 0, 64'h0,                   1, 0};

      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready32", 64'(r32), 64'd1);
      chk("rst_out_valid32", 64'(ov32), 64'd0);
      chk("rst_out_data32", 64'(od32), 64'd0);
      chk("rst_flags32", 64'({mis32, ovs32}), 64'd0);
      chk("rst_cnt32", 64'(cnt32), 64'd0);
      chk("rst_in_ready64", 64'(r64), 64'd1);
      chk("rst_out_valid64", 64'(ov64), 64'd0);
      @(negedge clk);
      rst = 0;

      for (int i = 0; i < 18; i++) send(tbl[i], 1'b0, $sformatf("vec%0d", i));

      // Back-to-back stream with output stalled for the first three cycles.
      k = 0; cons = 0; first = -1; last = -1;
      for (int cyc = 0; cyc < 40 && cons < 8; cyc++) begin
         @(negedge clk);
         ordy32 = (cyc >= 3);
         v32 = (k < 8); d32 = 32'hA500_0000 | 32'(k); off32 = 0; sz32 = 2'd2; sg32 = 0;
         #1;
         acc_now  = v32 && r32;
         cons_now = ov32 && ordy32;
         if (cyc == 1 || cyc == 2) chk("stall_hold", 64'(od32), 64'hA500_0000);
         if (cyc == 2) begin
            chk("stall_accepts", 64'(k), 64'd2);
            chk("stall_in_ready", 64'(r32), 64'd0);
         end
         if (cons_now) begin
            if (exp_q.size() == 0) chk("stream_underflow", 64'd1, 64'd0);
            else chk("stream_order", 64'(od32), 64'(exp_q.pop_front()));
            cons++;
            if (first < 0) first = cyc;
            last = cyc;
         end
         if (acc_now) begin
            exp_q.push_back(d32);
            k++;
         end
         @(posedge clk);
      end
      #1 v32 = 0;
      chk("stream_count", 64'(cons), 64'd8);
      chk("stream_rate", 64'(last - first), 64'd7);

      // Fill output and skid, then reset asynchronously between clock edges.
      @(negedge clk);
      ordy32 = 0; v32 = 1; d32 = 32'h1111_2222; off32 = 0; sz32 = 2'd2;
      @(negedge clk);
      d32 = 32'h3333_4444;
      @(negedge clk);
      v32 = 0;
      #1;
      chk("full_out_valid", 64'(ov32), 64'd1);
      chk("full_in_ready", 64'(r32), 64'd0);
      #2 rst = 1;
      #1;
      chk("async_out_valid", 64'(ov32), 64'd0);
      chk("async_in_ready", 64'(r32), 64'd1);
      chk("async_out_data", 64'(od32), 64'd0);
      chk("async_cnt32", 64'(cnt32), 64'd0);
      exp_cnt32 = 0; exp_cnt64 = 0;
      @(negedge clk);
      rst = 0;
      ordy32 = 1;
      @(negedge clk);
      #1 chk("post_rst_out_valid", 64'(ov32), 64'd0);

      // Saturation at CNT_WIDTH=2, then clear together with a flagged delivery.
      sat = '{1, 64'h8765_4321_0000_0000, 3'd2, 2'd2, 0, 64'h0, 1, 0};
      for (int i = 0; i < 4; i++) send(sat, 1'b0, $sformatf("sat%0d", i));
      chk("sat_hold", 64'(cnt64), 64'd3);
      send(sat, 1'b1, "clr_vs_inc");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
